// File: rtl/line_buffer_sequencer_if.sv
// Pixel-stream, buffer-write and window handshake bundle between the row-buffer
// write scheduler and its neighbours (pixel source, decoder, window engine).
interface line_buffer_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int ROW_W  = 9
);
    logic              frame_start;
    logic              pix_valid;
    logic              pix_ready;
    logic              write_enable;
    logic [2:0]        select;
    logic [ADDR_W-1:0] wr_addr;
    logic              win_valid;
    logic [2:0]        read_base;
    logic              row_ack;
    logic [ROW_W-1:0]  row_count;
    logic              frame_done;

    modport master (
        output frame_start, pix_valid, row_ack,
        input  pix_ready, write_enable, select, wr_addr,
               win_valid, read_base, row_count, frame_done
    );

    modport slave (
        input  frame_start, pix_valid, row_ack,
        output pix_ready, write_enable, select, wr_addr,
               win_valid, read_base, row_count, frame_done
    );
endinterface

// File: rtl/line_buffer_sequencer.sv
// Write-side scheduler for the six stereo row buffers: rotates the write buffer row by
// row and offers a 5-row read window, back-pressuring the stream while a window is unread.
module line_buffer_sequencer #(
    parameter int LINE_WIDTH = 640,
    parameter int FRAME_ROWS = 480,
    parameter int ADDR_W     = 10,
    parameter int ROW_W      = 9
) (
    input  logic clk,
    input  logic reset_n,
    line_buffer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FILL, STREAM, STALL, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(FRAME_ROWS - 1);
    localparam logic [2:0]        WIN_ROWS = 3'd5;

    state_t            state, next_state;
    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic [2:0]        sel;
    logic [2:0]        rows_stored;
    logic [2:0]        read_base;
    logic [2:0]        rows_next;
    logic [2:0]        base_next;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row_count;
    logic              pending;
    logic              pix_ready;
    logic              accept;
    logic              row_done;
    logic              stall_cond;
    logic              window_set;
    logic              last_row;

    // Reset takes effect immediately but is only released on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    assign stall_cond = pending && (col == LAST_COL);
    assign pix_ready  = !bus.frame_start &&
                        ((state == FILL) || ((state == STREAM) && !stall_cond));
    assign accept     = bus.pix_valid && pix_ready;
    assign row_done   = accept && (col == LAST_COL);
    assign rows_next  = (rows_stored == WIN_ROWS) ? WIN_ROWS : rows_stored + 3'd1;
    assign window_set = row_done && (rows_next == WIN_ROWS);
    assign last_row   = row_done && (row_count == LAST_ROW);
    // Oldest of the five most recent rows is two buffers past the one just finished.
    assign base_next  = (sel >= 3'd4) ? sel - 3'd4 : sel + 3'd2;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (bus.frame_start) begin
            next_state = FILL;
        end else begin
            unique case (state)
                IDLE: next_state = IDLE;
                FILL, STREAM: begin
                    if (last_row)
                        next_state = DRAIN;
                    else if (window_set)
                        next_state = STREAM;
                    else if ((state == STREAM) && stall_cond && !bus.row_ack)
                        next_state = STALL;
                end
                STALL: if (bus.row_ack) next_state = STREAM;
                DRAIN: if (!pending) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            col         <= '0;
            sel         <= '0;
            rows_stored <= '0;
            row_count   <= '0;
            pending     <= 1'b0;
            read_base   <= '0;
        end else if (bus.frame_start) begin
            col         <= '0;
            sel         <= '0;
            rows_stored <= '0;
            row_count   <= '0;
            pending     <= 1'b0;
        end else begin
            if (bus.row_ack && pending)
                pending <= 1'b0;
            if (accept) begin
                if (col != LAST_COL) begin
                    col <= col + ADDR_W'(1);
                end else begin
                    col         <= '0;
                    sel         <= (sel == 3'd5) ? 3'd0 : sel + 3'd1;
                    row_count   <= row_count + ROW_W'(1);
                    rows_stored <= rows_next;
                    if (window_set) begin
                        pending   <= 1'b1;
                        read_base <= base_next;
                    end
                end
            end
        end
    end

    assign bus.pix_ready    = pix_ready;
    assign bus.write_enable = accept;
    assign bus.select       = sel;
    assign bus.wr_addr      = col;
    assign bus.win_valid    = pending;
    assign bus.read_base    = read_base;
    assign bus.row_count    = row_count;
    assign bus.frame_done   = (state == DRAIN) && !pending;
endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Self-checking bench for line_buffer_sequencer: directed scenarios plus random traffic,
// compared every cycle against a pixel-count based reference model.
module tb_line_buffer_sequencer;
    localparam int LW = 4;
    localparam int FR = 8;
    localparam int AW = 3;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   check_count = 0;
    int   pass_count  = 0;
    int   cycle       = 0;

    // Reference model: frame progress is just the number of accepted pixels.
    bit   m_active;
    bit   m_pending;
    bit   m_drain;
    int   m_pix;
    int   m_rb;

    logic obs_ready;
    logic obs_we;
    logic obs_done;

    line_buffer_sequencer_if #(.ADDR_W(AW), .ROW_W(RW)) bus ();

    line_buffer_sequencer #(
        .LINE_WIDTH(LW),
        .FRAME_ROWS(FR),
        .ADDR_W(AW),
        .ROW_W(RW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed == expected)
            pass_count++;
        else
            $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d",
                     tag, cycle, observed, expected);
    endtask

    task automatic modelReset();
        m_active  = 1'b0;
        m_pending = 1'b0;
        m_drain   = 1'b0;
        m_pix     = 0;
        m_rb      = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pix_ready"},    int'(bus.pix_ready),    0);
        checkOutput({tag, "_write_enable"}, int'(bus.write_enable), 0);
        checkOutput({tag, "_select"},       int'(bus.select),       0);
        checkOutput({tag, "_wr_addr"},      int'(bus.wr_addr),      0);
        checkOutput({tag, "_read_base"},    int'(bus.read_base),    0);
        checkOutput({tag, "_row_count"},    int'(bus.row_count),    0);
        checkOutput({tag, "_win_valid"},    int'(bus.win_valid),    0);
        checkOutput({tag, "_frame_done"},   int'(bus.frame_done),   0);
    endtask

    // One clock cycle: drive inputs, check every output mid-cycle, then advance the model.
    task automatic applyStimulus(input bit fs, input bit pv, input bit ack);
        int col;
        int rows;
        bit exp_ready;
        bit exp_we;
        bit exp_done;
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        bus.row_ack     = ack;
        col       = m_pix % LW;
        rows      = m_pix / LW;
        exp_ready = m_active && !m_drain && !fs && !(m_pending && (col == LW - 1));
        exp_we    = exp_ready && pv;
        exp_done  = m_drain && !m_pending;
        @(negedge clk);
        obs_ready = bus.pix_ready;
        obs_we    = bus.write_enable;
        obs_done  = bus.frame_done;
        checkOutput("pix_ready",    int'(bus.pix_ready),    int'(exp_ready));
        checkOutput("write_enable", int'(bus.write_enable), int'(exp_we));
        checkOutput("select",       int'(bus.select),       rows % 6);
        checkOutput("wr_addr",      int'(bus.wr_addr),      col);
        checkOutput("win_valid",    int'(bus.win_valid),    int'(m_pending));
        checkOutput("read_base",    int'(bus.read_base),    m_rb);
        checkOutput("row_count",    int'(bus.row_count),    rows);
        checkOutput("frame_done",   int'(bus.frame_done),   int'(exp_done));
        @(posedge clk);
        cycle++;
        if (fs) begin
            m_active  = 1'b1;
            m_pix     = 0;
            m_pending = 1'b0;
            m_drain   = 1'b0;
        end else begin
            if (ack && m_pending) m_pending = 1'b0;
            if (exp_done) begin
                m_active = 1'b0;
                m_drain  = 1'b0;
            end
            if (exp_we) begin
                m_pix++;
                if (m_pix % LW == 0) begin
                    rows = m_pix / LW;
                    if (rows >= 5) begin
                        m_pending = 1'b1;
                        m_rb      = (rows - 5) % 6;
                    end
                    if (rows == FR) m_drain = 1'b1;
                end
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int we_count;
        int done_count;
        bit fs;
        bit pv;
        bit ack;

        reset_n         = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.row_ack     = 1'b0;
        modelReset();
        #1 reset_n = 1'b0;
        #2 checkResetValues("por");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        // Fill five rows back to back.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("fill_win_valid", int'(bus.win_valid), 1);
        checkOutput("fill_read_base", int'(bus.read_base), 0);
        checkOutput("fill_row_count", int'(bus.row_count), 5);

        // Unacknowledged window stalls the end of row six.
        repeat (13) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stall_ready", int'(obs_ready), 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("ack_ready", int'(bus.pix_ready), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("row6_read_base", int'(bus.read_base), 1);
        checkOutput("row6_select",    int'(bus.select),    0);
        for (int n = 0; n < 100 && m_active; n++)
            applyStimulus(1'b0, 1'b1, m_pending);

        // Full frame with immediate acknowledges never stalls.
        applyStimulus(1'b1, 1'b0, 1'b0);
        we_count = 0;
        for (int n = 0; n < 32; n++) begin
            applyStimulus(1'b0, 1'b1, m_pending);
            we_count += int'(obs_we);
        end
        checkOutput("burst_accepts", we_count, 32);
        done_count = 0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b0, 1'b0, m_pending);
            done_count += int'(obs_done);
        end
        checkOutput("frame_done_pulses", done_count, 1);
        checkOutput("idle_ready", int'(obs_ready), 0);

        // Restart in the middle of row three.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("restart_ready",     int'(obs_ready),     0);
        checkOutput("restart_select",    int'(bus.select),    0);
        checkOutput("restart_wr_addr",   int'(bus.wr_addr),   0);
        checkOutput("restart_row_count", int'(bus.row_count), 0);

        // Acknowledge with no window outstanding.
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("spurious_wr_addr",   int'(bus.wr_addr),   1);
        checkOutput("spurious_select",    int'(bus.select),    1);
        checkOutput("spurious_win_valid", int'(bus.win_valid), 0);

        // Asynchronous reset while a window is outstanding.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pre_reset_win_valid", int'(bus.win_valid), 1);
        checkOutput("pre_reset_read_base", int'(bus.read_base), 1);
        #2 reset_n = 1'b0;
        #1 checkResetValues("async_rst");
        modelReset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        // Random traffic, restarts and acknowledges.
        for (int n = 0; n < 1500; n++) begin
            fs  = (!m_active && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0);
            pv  = ($urandom_range(0, 3) != 0);
            ack = (m_pending && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 9) == 0);
            applyStimulus(fs, pv, ack);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
